// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
//   word_t         32-bit word handed to the core
//   WORDS_PER_BLK  words per 512-bit block
//   LEN_HI_IDX / LEN_LO_IDX  word slots holding the 64-bit bit length
//   PAD_BYTE       first padding byte appended after the message
//   pad_state_e    padder FSM states
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int         WORDS_PER_BLK = 16;
    localparam int         LEN_HI_IDX    = 14;
    localparam int         LEN_LO_IDX    = 15;
    localparam logic [7:0] PAD_BYTE      = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PAD    = 3'd2,
        ST_ZERO   = 3'd3,
        ST_LEN_HI = 3'd4,
        ST_LEN_LO = 3'd5,
        ST_DONE   = 3'd6
    } pad_state_e;

endpackage

// File: rtl/sha256_word_packer.sv
// Beat-to-word shift buffer. Bytes enter at the LSB end so the first byte of
// the word ends up in the MSBs (big-endian).
//   clk, resetn   clock / async active-low reset
//   clr_i         drop the buffered word (it has been handed to the core)
//   load_i        shift in the first nbytes_i bytes of data_i (MSB byte first)
//   word_o        raw buffer, valid as a full word when full_o=1
//   pad_word_o    buffered bytes left-aligned, then PAD_BYTE, then zeros
//   full_o        four bytes buffered
module sha256_word_packer
    import sha256_pkg::*;
#(
    parameter  int IN_BYTES = 4,
    localparam int NB_W     = $clog2(IN_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [8*IN_BYTES-1:0] data_i,
    input  logic [NB_W-1:0]       nbytes_i,
    output word_t                 word_o,
    output word_t                 pad_word_o,
    output logic                  full_o
);

    word_t      buf_q, buf_d;
    logic [2:0] cnt_q, cnt_d;

    // Clear applies before the load so a same-cycle clear+load starts a fresh word.
    always_comb begin
        buf_d = clr_i ? '0 : buf_q;
        cnt_d = clr_i ? '0 : cnt_q;
        if (load_i) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (i < int'(nbytes_i)) begin
                    buf_d = {buf_d[23:0], data_i[8*(IN_BYTES-1-i) +: 8]};
                    cnt_d = cnt_d + 3'd1;
                end
            end
        end
    end

    always_comb begin
        case (cnt_q)
            3'd0:    pad_word_o = {PAD_BYTE, 24'h0};
            3'd1:    pad_word_o = {buf_q[7:0], PAD_BYTE, 16'h0};
            3'd2:    pad_word_o = {buf_q[15:0], PAD_BYTE, 8'h0};
            3'd3:    pad_word_o = {buf_q[23:0], PAD_BYTE};
            default: pad_word_o = buf_q;
        endcase
    end

    assign word_o = buf_q;
    assign full_o = cnt_q[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams a byte message into sha256_core as padded 32-bit words: message
// words, 0x80 + zero fill, then the 64-bit bit length, adding a block when
// the pad lands in the length slots.
//   clk, resetn                   clock / async active-low reset
//   in_data/in_nbytes/in_valid/in_last/in_ready   byte-beat input stream
//   data, wr_en                   word and one-cycle write strobe to the core
//   wr_ready, blk_ready           core can take a word / start a new block
//   msg_done                      pulse after the last length word is written
//   busy                          message in progress
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter  int IN_BYTES = 4,
    parameter  int LEN_W    = 32,
    localparam int NB_W     = $clog2(IN_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [8*IN_BYTES-1:0] in_data,
    input  logic [NB_W-1:0]       in_nbytes,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output word_t                 data,
    output logic                  wr_en,
    input  logic                  wr_ready,
    input  logic                  blk_ready,
    output logic                  msg_done,
    output logic                  busy
);

    localparam int WIDX_W = $clog2(WORDS_PER_BLK);
    localparam logic [WIDX_W-1:0] LAST_FILL_IDX = WIDX_W'(LEN_HI_IDX - 1);

    pad_state_e        state_q, state_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [LEN_W-1:0]  len_q, len_d, len_sat;
    logic [LEN_W:0]    len_sum;
    word_t             data_q, data_d, word_sel, pk_word, pk_pad;
    logic              wr_en_q, done_q, done_d, busy_q, busy_d, rdy_en_q;
    logic              pending, fire, accept, pk_clr, pk_full;
    logic [NB_W-1:0]   nb_eff;
    logic [63:0]       bitlen;

    // Non-last beats always carry a full beat regardless of in_nbytes.
    assign nb_eff  = in_last ? in_nbytes : NB_W'(IN_BYTES);
    assign accept  = in_valid && in_ready;
    assign len_sum = {1'b0, len_q} + (LEN_W+1)'(nb_eff);
    assign len_sat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    assign bitlen  = {{(61-LEN_W){1'b0}}, len_q, 3'b000};

    // rdy_en_q keeps in_ready low during reset and lets it rise one cycle after.
    assign in_ready = rdy_en_q && (state_q == ST_IDLE || (state_q == ST_DATA && !pk_full));

    sha256_word_packer #(.IN_BYTES(IN_BYTES)) u_packer (
        .clk        (clk),
        .resetn     (resetn),
        .clr_i      (pk_clr),
        .load_i     (accept),
        .data_i     (in_data),
        .nbytes_i   (nb_eff),
        .word_o     (pk_word),
        .pad_word_o (pk_pad),
        .full_o     (pk_full)
    );

    always_comb begin
        pending  = 1'b0;
        word_sel = '0;
        case (state_q)
            ST_DATA:   begin pending = pk_full; word_sel = pk_word; end
            ST_PAD:    begin pending = 1'b1; word_sel = pk_full ? pk_word : pk_pad; end
            ST_ZERO:   pending = 1'b1;
            ST_LEN_HI: begin pending = 1'b1; word_sel = bitlen[63:32]; end
            ST_LEN_LO: begin pending = 1'b1; word_sel = bitlen[31:0]; end
            default:   ;
        endcase
    end

    // !wr_en_q enforces the idle cycle between strobes; word 0 also needs blk_ready.
    assign fire = pending && wr_ready && !wr_en_q && (widx_q != '0 || blk_ready);

    always_comb begin
        state_d = state_q;
        widx_d  = fire ? widx_q + 1'b1 : widx_q;
        data_d  = fire ? word_sel : data_q;
        len_d   = len_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pk_clr  = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = in_last ? ST_PAD : ST_DATA;
                busy_d  = 1'b1;
                len_d   = LEN_W'(nb_eff);
            end
            ST_DATA: begin
                pk_clr = fire;
                if (accept) begin
                    len_d = len_sat;
                    if (in_last) state_d = ST_PAD;
                end
            end
            // A last beat that filled the buffer is flushed first, then the pad word.
            // A pad at word 13 leaves 14/15 for the length; anything else zero-fills
            // up to word 13 (of the next block if the pad landed in 14/15).
            ST_PAD: if (fire) begin
                pk_clr = 1'b1;
                if (!pk_full) state_d = (widx_q == LAST_FILL_IDX) ? ST_LEN_HI : ST_ZERO;
            end
            ST_ZERO:   if (fire && widx_q == LAST_FILL_IDX) state_d = ST_LEN_HI;
            ST_LEN_HI: if (fire) state_d = ST_LEN_LO;
            ST_LEN_LO: if (fire) state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            widx_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            widx_q   <= widx_d;
            len_q    <= len_d;
            data_q   <= data_d;
            wr_en_q  <= fire;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign data     = data_q;
    assign wr_en    = wr_en_q;
    assign msg_done = done_q;
    assign busy     = busy_q;

endmodule
